// File: rtl/sprite_blitter_pkg.sv
// -----------------------------------------------------------------------------
// sprite_blitter_pkg
//   Shared definitions for the Chip-8 DXYN sprite blitter: default geometry of
//   the CPU memory and the byte-wide monochrome framebuffer, and the FSM state
//   encoding used by the blitter controller.
// -----------------------------------------------------------------------------
package sprite_blitter_pkg;

    // Default geometry: 4 KiB CPU memory, 64x32 pixel framebuffer stored as
    // 8 bytes per row, 32 rows -> 256 bytes.
    localparam int DEF_MEM_AW  = 12;
    localparam int DEF_FB_COLS = 64;
    localparam int DEF_FB_ROWS = 32;
    localparam int DEF_FB_AW   = 8;

    // Pixels packed per framebuffer byte; bit 7 is the leftmost pixel.
    localparam int PIX_PER_BYTE = 8;

    // Controller states. FB0* touch the byte holding the sprite's left edge,
    // FB1* the following byte when the sprite straddles a byte boundary.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MEM  = 3'd1,
        ST_FB0R = 3'd2,
        ST_FB0W = 3'd3,
        ST_FB1R = 3'd4,
        ST_FB1W = 3'd5,
        ST_DONE = 3'd6
    } blit_state_t;

endpackage : sprite_blitter_pkg

// File: rtl/sprite_blitter_row_shift.sv
// -----------------------------------------------------------------------------
// sprite_row_shift
//   Splits one 8-pixel sprite row across the two framebuffer bytes it may
//   overlap when drawn at a pixel offset within a byte.
//
// Ports
//   spr     in  8  sprite row, bit 7 = leftmost pixel
//   off     in  3  pixel offset of the sprite inside its first byte (x mod 8)
//   pat_hi  out 8  pixels landing in the first byte  (spr >> off)
//   pat_lo  out 8  pixels spilling into the next byte ((spr << (8-off)) mod 256)
// -----------------------------------------------------------------------------
module sprite_row_shift (
    input  logic [7:0] spr,
    input  logic [2:0] off,
    output logic [7:0] pat_hi,
    output logic [7:0] pat_lo
);

    // Shifting the row through a 16-bit window yields both halves at once;
    // with off = 0 the low half is naturally all zeros.
    logic [15:0] window;

    always_comb begin
        window = {spr, 8'h00} >> off;
    end

    assign pat_hi = window[15:8];
    assign pat_lo = window[7:0];

endmodule : sprite_row_shift

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//   Executes Chip-8 DXYN. Fetches N sprite rows from CPU memory starting at I
//   (1-cycle read latency), XORs each row into the byte-wide framebuffer with
//   horizontal and vertical wrap, and reports whether any lit pixel was
//   turned off (VF). The CPU stalls while busy is high.
//
// Ports
//   clk         in   1       clock, all logic on rising edge
//   reset       in   1       synchronous, active-high
//   start       in   1       draw request, only looked at while idle
//   x, y        in   6/5     sprite origin, taken modulo framebuffer size
//   n           in   4       sprite height in rows (0 completes immediately)
//   i_addr      in   MEM_AW  sprite base address in CPU memory
//   busy        out  1       operation in progress (through the done cycle)
//   done        out  1       one-cycle pulse on the final cycle
//   collision   out  1       any set pixel cleared; held until next start
//   mem_en      out  1       CPU memory read enable
//   mem_addr    out  MEM_AW  CPU memory read address
//   mem_data    in   8       CPU memory read data, cycle after mem_en
//   fb_addr     out  FB_AW   framebuffer byte address {row, column byte}
//   fb_rd_data  in   8       framebuffer read data, cycle after fb_addr
//   fb_we       out  1       framebuffer write strobe
//   fb_wr_data  out  8       framebuffer write data, bit 7 = leftmost pixel
// -----------------------------------------------------------------------------
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int MEM_AW  = DEF_MEM_AW,
    parameter int FB_COLS = DEF_FB_COLS,
    parameter int FB_ROWS = DEF_FB_ROWS,
    parameter int FB_AW   = DEF_FB_AW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(FB_COLS)-1:0] x,
    input  logic [$clog2(FB_ROWS)-1:0] y,
    input  logic [3:0]                 n,
    input  logic [MEM_AW-1:0]          i_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       collision,
    output logic                       mem_en,
    output logic [MEM_AW-1:0]          mem_addr,
    input  logic [7:0]                 mem_data,
    output logic [FB_AW-1:0]           fb_addr,
    input  logic [7:0]                 fb_rd_data,
    output logic                       fb_we,
    output logic [7:0]                 fb_wr_data
);

    localparam int X_W  = $clog2(FB_COLS);
    localparam int Y_W  = $clog2(FB_ROWS);
    localparam int CB_W = X_W - $clog2(PIX_PER_BYTE);   // column-byte index width

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    blit_state_t       state_q, state_d;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [3:0]        n_q;
    logic [MEM_AW-1:0] i_q;
    logic [3:0]        row_q;
    logic [7:0]        spr_q;
    logic              coll_q;

    // ------------------------------------------------------------------
    // Derived addressing
    // ------------------------------------------------------------------
    logic [2:0]      off;
    logic [Y_W-1:0]  fb_row;
    logic [CB_W-1:0] col0, col1;
    logic            last_row;
    logic            row_advance;
    logic [7:0]      pat_hi, pat_lo, pat;
    logic            hit;

    assign off    = x_q[2:0];
    // Both sums wrap by width: vertical wrap over rows, horizontal wrap of
    // the second byte back to column byte 0 of the same row.
    assign fb_row = y_q + Y_W'(row_q);
    assign col0   = x_q[X_W-1:3];
    assign col1   = col0 + CB_W'(1);

    assign last_row    = ({1'b0, row_q} + 5'd1) == {1'b0, n_q};
    assign row_advance = ((state_q == ST_FB0W) && (off == 3'd0)) || (state_q == ST_FB1W);

    sprite_row_shift u_row_shift (
        .spr    (spr_q),
        .off    (off),
        .pat_hi (pat_hi),
        .pat_lo (pat_lo)
    );

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no
        // path can leave one unassigned and infer a latch.
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        fb_addr    = '0;
        fb_we      = 1'b0;
        fb_wr_data = '0;
        pat        = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n == 4'd0) ? ST_DONE : ST_MEM;
                end
            end

            ST_MEM: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = i_q + MEM_AW'(row_q);
                state_d  = ST_FB0R;
            end

            ST_FB0R: begin
                busy    = 1'b1;
                fb_addr = {fb_row, col0};
                state_d = ST_FB0W;
            end

            ST_FB0W: begin
                busy       = 1'b1;
                fb_addr    = {fb_row, col0};
                fb_we      = 1'b1;
                pat        = pat_hi;
                fb_wr_data = fb_rd_data ^ pat_hi;
                if (off != 3'd0) begin
                    state_d = ST_FB1R;
                end else begin
                    state_d = last_row ? ST_DONE : ST_MEM;
                end
            end

            ST_FB1R: begin
                busy    = 1'b1;
                fb_addr = {fb_row, col1};
                state_d = ST_FB1W;
            end

            ST_FB1W: begin
                busy       = 1'b1;
                fb_addr    = {fb_row, col1};
                fb_we      = 1'b1;
                pat        = pat_lo;
                fb_wr_data = fb_rd_data ^ pat_lo;
                state_d    = last_row ? ST_DONE : ST_MEM;
            end

            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A pixel set in both the framebuffer and the sprite is about to be cleared.
    assign hit = fb_we && (|(fb_rd_data & pat));

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values and evaluation order inside the block is irrelevant.
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            row_q   <= '0;
            spr_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == ST_IDLE) && start) begin
                x_q    <= x;
                y_q    <= y;
                n_q    <= n;
                i_q    <= i_addr;
                row_q  <= '0;
                coll_q <= 1'b0;
            end

            // Memory data requested in ST_MEM is valid during ST_FB0R.
            if (state_q == ST_FB0R) begin
                spr_q <= mem_data;
            end

            if (hit) begin
                coll_q <= 1'b1;
            end

            if (row_advance) begin
                row_q <= row_q + 4'd1;
            end
        end
    end

    assign collision = coll_q;

endmodule : sprite_blitter

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
//   Self-checking bench for sprite_blitter. Models the CPU memory and the
//   framebuffer RAM (both 1-cycle registered reads), predicts every memory
//   read and framebuffer write with a pixel-level model, and compares them
//   in order as the DUT issues them.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  x = '0;
    logic [4:0]  y = '0;
    logic [3:0]  n = '0;
    logic [11:0] i_addr = '0;
    logic        busy, done, collision, mem_en, fb_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_rd_data = '0;
    logic [7:0]  fb_wr_data;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x          (x),
        .y          (y),
        .n          (n),
        .i_addr     (i_addr),
        .busy       (busy),
        .done       (done),
        .collision  (collision),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .fb_addr    (fb_addr),
        .fb_rd_data (fb_rd_data),
        .fb_we      (fb_we),
        .fb_wr_data (fb_wr_data)
    );

    // Memories around the DUT
    logic [7:0] cpu_mem [0:4095];
    logic [7:0] fb_ram  [0:255] = '{default: 8'h00};
    logic [7:0] exp_fb  [0:255];

    always @(posedge clk) begin
        if (mem_en) mem_data <= cpu_mem[mem_addr];
    end

    always @(posedge clk) begin
        fb_rd_data <= fb_ram[fb_addr];
        if (fb_we) fb_ram[fb_addr] <= fb_wr_data;
    end

    // Scoreboard
    logic [11:0] mem_q [$];
    logic [15:0] wr_q  [$];
    int n_compared   = 0;
    int n_mismatched = 0;
    bit mon_on       = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_en || fb_we) check("one_strobe", 32'(mem_en & fb_we), 32'd0);
            if (mem_en) begin
                if (mem_q.size() == 0) check("mem_unexpected", 32'(mem_en), 32'd0);
                else                   check("mem_addr", 32'(mem_addr), 32'(mem_q.pop_front()));
            end
            if (fb_we) begin
                if (wr_q.size() == 0) check("fb_unexpected", 32'(fb_we), 32'd0);
                else                  check("fb_write", 32'({fb_addr, fb_wr_data}), 32'(wr_q.pop_front()));
            end
        end
    end

    // Pixel-level model: plots each sprite pixel individually with wrap.
    task automatic model_draw(input logic [5:0] dx, input logic [4:0] dy, input logic [3:0] dn,
                              input logic [11:0] di, output bit coll);
        coll = 1'b0;
        for (int r = 0; r < int'(dn); r++) begin
            logic [11:0] a;
            logic [7:0]  s;
            logic [7:0]  p0, p1;
            int py, b0, b1, idx0, idx1, px;
            a  = di + 12'(r);
            s  = cpu_mem[a];
            py = (int'(dy) + r) % 32;
            b0 = int'(dx) / 8;
            b1 = (b0 + 1) % 8;
            p0 = '0;
            p1 = '0;
            mem_q.push_back(a);
            for (int b = 0; b < 8; b++) begin
                if (s[7-b]) begin
                    px = (int'(dx) + b) % 64;
                    if (px / 8 == b0) p0[7 - px % 8] = 1'b1;
                    else              p1[7 - px % 8] = 1'b1;
                end
            end
            idx0 = py * 8 + b0;
            wr_q.push_back({8'(idx0), exp_fb[idx0] ^ p0});
            if ((exp_fb[idx0] & p0) != 8'h00) coll = 1'b1;
            exp_fb[idx0] = exp_fb[idx0] ^ p0;
            if (dx % 8 != 0) begin
                idx1 = py * 8 + b1;
                wr_q.push_back({8'(idx1), exp_fb[idx1] ^ p1});
                if ((exp_fb[idx1] & p1) != 8'h00) coll = 1'b1;
                exp_fb[idx1] = exp_fb[idx1] ^ p1;
            end
        end
    endtask

    task automatic draw(input string name, input logic [5:0] dx, input logic [4:0] dy,
                        input logic [3:0] dn, input logic [11:0] di, input bit poke_busy);
        bit exp_coll;
        int cycles;
        int exp_cycles;
        model_draw(dx, dy, dn, di, exp_coll);
        exp_cycles = ((dx[2:0] == 3'd0) ? 3 : 5) * int'(dn) + 1;

        @(negedge clk);
        start = 1'b1; x = dx; y = dy; n = dn; i_addr = di;
        @(posedge clk);                     // accepted on this edge
        @(negedge clk);
        // Operands need not be held after acceptance.
        start = 1'b0; x = ~dx; y = ~dy; n = 4'hF; i_addr = ~di;
        cycles = 1;
        check({name, "_busy_c1"}, 32'(busy), 32'd1);
        while (!done && cycles < 200) begin
            start = (poke_busy && cycles == 2);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(cycles), 32'(exp_cycles));
        check({name, "_collision"}, 32'(collision), 32'(exp_coll));
        @(negedge clk);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_coll_held"}, 32'(collision), 32'(exp_coll));
        check({name, "_mem_q_left"}, 32'(mem_q.size()), 32'd0);
        check({name, "_wr_q_left"}, 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet_seen;
        int diffs;

        for (int k = 0; k < 4096; k++) cpu_mem[k] = 8'h00;
        for (int k = 0; k < 256; k++)  exp_fb[k]  = 8'h00;
        cpu_mem[0] = 8'hF0; cpu_mem[1] = 8'h90; cpu_mem[2] = 8'h90;
        cpu_mem[3] = 8'h90; cpu_mem[4] = 8'hF0;
        cpu_mem[12'h200] = 8'hFF;
        cpu_mem[12'h201] = 8'hFF;
        cpu_mem[12'hFFF] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        reset = 1'b0;
        mon_on = 1'b1;

        // Font glyph on a blank framebuffer
        draw("font", 6'd0, 5'd0, 4'd5, 12'h000, 1'b0);
        check("font_fb0",  32'(fb_ram[0]),  32'hF0);
        check("font_fb8",  32'(fb_ram[8]),  32'h90);
        check("font_fb16", 32'(fb_ram[16]), 32'h90);
        check("font_fb24", 32'(fb_ram[24]), 32'h90);
        check("font_fb32", 32'(fb_ram[32]), 32'hF0);

        // Redraw erases it and collides
        draw("redraw", 6'd0, 5'd0, 4'd5, 12'h000, 1'b0);
        check("redraw_fb0",  32'(fb_ram[0]),  32'h00);
        check("redraw_fb32", 32'(fb_ram[32]), 32'h00);

        // n = 0: immediate done, collision cleared
        draw("n0", 6'd3, 5'd3, 4'd0, 12'h000, 1'b0);

        // Unaligned single row, with a start pulse while busy
        draw("unaligned", 6'd4, 5'd1, 4'd1, 12'h200, 1'b1);
        check("unaligned_fb8", 32'(fb_ram[8]), 32'h0F);
        check("unaligned_fb9", 32'(fb_ram[9]), 32'hF0);

        // Reset during FB1R aborts the draw
        mon_on = 1'b0;
        @(negedge clk);
        start = 1'b1; x = 6'd4; y = 5'd1; n = 4'd2; i_addr = 12'h200;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort_mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("abort_fb0w", 32'({fb_we, fb_addr, fb_wr_data}), 32'({1'b1, 8'd8, 8'h00}));
        @(negedge clk);
        check("abort_fb1r_we", 32'(fb_we), 32'd0);
        check("abort_fb1r_coll", 32'(collision), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fb_we", 32'(fb_we), 32'd0);
        check("abort_collision", 32'(collision), 32'd0);
        reset = 1'b0;
        quiet_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            quiet_seen |= fb_we | done | busy | mem_en;
        end
        check("abort_quiet", 32'(quiet_seen), 32'd0);
        exp_fb[8] = exp_fb[8] ^ 8'h0F;
        mon_on = 1'b1;

        // Horizontal and vertical wrap, address wrap FFF -> 000
        cpu_mem[0] = 8'hFF;
        draw("wrap", 6'd61, 5'd31, 4'd2, 12'hFFF, 1'b1);
        check("wrap_fb255", 32'(fb_ram[255]), 32'h07);
        check("wrap_fb248", 32'(fb_ram[248]), 32'hF8);
        check("wrap_fb7",   32'(fb_ram[7]),   32'h07);
        check("wrap_fb0",   32'(fb_ram[0]),   32'hF8);

        // A few random sprites over the existing picture
        for (int k = 0; k < 64; k++) cpu_mem[12'h300 + k] = 8'($urandom);
        for (int t = 0; t < 6; t++) begin
            draw("rand", 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(1, 15)), 12'h300 + 12'($urandom_range(0, 40)), 1'b1);
        end

        diffs = 0;
        for (int k = 0; k < 256; k++) if (fb_ram[k] !== exp_fb[k]) diffs++;
        check("fb_final_diff", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_sprite_blitter
